// File: rtl/accelerator_data_feeder_pkg.sv
// Shared definitions for the accelerator data feeder: sizes, FSM encoding, config bits.
package accelerator_data_feeder_pkg;

   localparam int BIT_WIDTH   = 8;
   localparam int NUM_CHANNEL = 3;
   localparam int NUM_KERNEL  = 4;
   localparam int ADDR_WIDTH  = 10;
   localparam int REG_WIDTH   = 32;

   // Bit of i_conf_ctrl whose rising edge launches a job
   localparam int CONF_START  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_W = 2'd1,
      ST_STREAM = 2'd2,
      ST_FINISH = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/feeder_rd_port.sv
// One BRAM read port: latched base, read counter, 1-cycle valid pipe and output hold register.
module feeder_rd_port #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic                  issue_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  val_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic [ADDR_WIDTH:0]   cnt_d;
   logic                  val_q;
   logic [DATA_WIDTH-1:0] hold_q;

   // Counter restarts on a new job and advances once per issued read
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (issue_i) begin
         cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
      end
   end

   // Base/count state, valid delay matching BRAM latency, and hold of last delivered word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q <= '0;
         cnt_q  <= '0;
         val_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         if (load_i) begin
            base_q <= base_i;
         end
         cnt_q <= cnt_d;
         val_q <= issue_i;
         if (val_q) begin
            hold_q <= rdata_i;
         end
      end
   end

   // Address wraps naturally: the count's carry bit is dropped
   assign mem_en_o   = issue_i;
   assign mem_addr_o = base_q + cnt_q[ADDR_WIDTH-1:0];
   assign count_o    = cnt_q;
   assign val_o      = val_q;
   // BRAM output register is presented on the valid cycle, held value otherwise
   assign data_o     = val_q ? rdata_i : hold_q;

endmodule

// File: rtl/accelerator_data_feeder.sv
// Feeds accelerator_core: loads a weight block, then answers data requests from data BRAM.
module accelerator_data_feeder
   import accelerator_data_feeder_pkg::*;
#(
   parameter int P_BIT_WIDTH   = BIT_WIDTH,
   parameter int P_NUM_CHANNEL = NUM_CHANNEL,
   parameter int P_NUM_KERNEL  = NUM_KERNEL,
   parameter int P_ADDR_WIDTH  = ADDR_WIDTH,
   parameter int P_REG_WIDTH   = REG_WIDTH
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [P_REG_WIDTH-1:0]                          i_conf_ctrl,
   input  logic [P_ADDR_WIDTH-1:0]                         i_conf_dbase,
   input  logic [P_ADDR_WIDTH:0]                           i_conf_dlen,
   input  logic [P_ADDR_WIDTH-1:0]                         i_conf_wbase,
   input  logic [P_ADDR_WIDTH:0]                           i_conf_wlen,
   input  logic                                            i_data_req,
   output logic [P_BIT_WIDTH*P_NUM_CHANNEL-1:0]            o_data,
   output logic                                            o_data_val,
   output logic [P_BIT_WIDTH*P_NUM_CHANNEL*P_NUM_KERNEL-1:0] o_weight,
   output logic                                            o_weight_val,
   output logic                                            o_dmem_en,
   output logic [P_ADDR_WIDTH-1:0]                         o_dmem_addr,
   input  logic [P_BIT_WIDTH*P_NUM_CHANNEL-1:0]            i_dmem_rdata,
   output logic                                            o_wmem_en,
   output logic [P_ADDR_WIDTH-1:0]                         o_wmem_addr,
   input  logic [P_BIT_WIDTH*P_NUM_CHANNEL*P_NUM_KERNEL-1:0] i_wmem_rdata,
   output logic                                            o_busy,
   output logic                                            o_done
);

   localparam int DW = P_BIT_WIDTH * P_NUM_CHANNEL;
   localparam int WW = DW * P_NUM_KERNEL;

   feeder_state_e         state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  start_prev_q;
   logic [P_ADDR_WIDTH:0] dlen_q;
   logic [P_ADDR_WIDTH:0] wlen_q;

   logic                  start_edge;
   logic                  job_load;
   logic                  w_issue;
   logic                  d_issue;
   logic [P_ADDR_WIDTH:0] wcnt;
   logic [P_ADDR_WIDTH:0] dcnt;

   // Only the start bit of the control register is meaningful
   logic ctrl_unused;
   assign ctrl_unused = ^i_conf_ctrl[P_REG_WIDTH-1:1];

   // Start is a rising edge; edges outside IDLE are dropped
   assign start_edge = i_conf_ctrl[CONF_START] & ~start_prev_q;
   assign job_load   = (state_q == ST_IDLE) && start_edge;
   assign w_issue    = (state_q == ST_LOAD_W) && (wcnt < wlen_q);
   assign d_issue    = (state_q == ST_STREAM) && i_data_req && (dcnt < dlen_q);

   // Job sequencer with registered busy/done flags and latched lengths
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         start_prev_q <= 1'b0;
         dlen_q       <= '0;
         wlen_q       <= '0;
      end else begin
         start_prev_q <= i_conf_ctrl[CONF_START];
         done_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_edge) begin
                  state_q <= ST_LOAD_W;
                  busy_q  <= 1'b1;
                  dlen_q  <= i_conf_dlen;
                  wlen_q  <= i_conf_wlen;
               end
            end
            ST_LOAD_W: begin
               if (wcnt == wlen_q) begin
                  if (dlen_q == '0) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               // Reaching dlen means the last read was issued last cycle and has landed
               if (dcnt == dlen_q) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   feeder_rd_port #(
      .ADDR_WIDTH (P_ADDR_WIDTH),
      .DATA_WIDTH (WW)
   ) u_wport (
      .clk        (clk),
      .rst        (rst),
      .load_i     (job_load),
      .base_i     (i_conf_wbase),
      .issue_i    (w_issue),
      .rdata_i    (i_wmem_rdata),
      .mem_en_o   (o_wmem_en),
      .mem_addr_o (o_wmem_addr),
      .count_o    (wcnt),
      .val_o      (o_weight_val),
      .data_o     (o_weight)
   );

   feeder_rd_port #(
      .ADDR_WIDTH (P_ADDR_WIDTH),
      .DATA_WIDTH (DW)
   ) u_dport (
      .clk        (clk),
      .rst        (rst),
      .load_i     (job_load),
      .base_i     (i_conf_dbase),
      .issue_i    (d_issue),
      .rdata_i    (i_dmem_rdata),
      .mem_en_o   (o_dmem_en),
      .mem_addr_o (o_dmem_addr),
      .count_o    (dcnt),
      .val_o      (o_data_val),
      .data_o     (o_data)
   );

   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_accelerator_data_feeder.sv
// Directed bench: vector table of jobs plus reset corner sequences, with BRAM models.
module tb_accelerator_data_feeder;

   logic          clk;
   logic          rst;
   logic [31:0]   i_conf_ctrl;
   logic [9:0]    i_conf_dbase;
   logic [10:0]   i_conf_dlen;
   logic [9:0]    i_conf_wbase;
   logic [10:0]   i_conf_wlen;
   logic          i_data_req;
   logic [23:0]   o_data;
   logic          o_data_val;
   logic [95:0]   o_weight;
   logic          o_weight_val;
   logic          o_dmem_en;
   logic [9:0]    o_dmem_addr;
   logic [23:0]   i_dmem_rdata;
   logic          o_wmem_en;
   logic [9:0]    o_wmem_addr;
   logic [95:0]   i_wmem_rdata;
   logic          o_busy;
   logic          o_done;

   int n_chk;
   int n_pass;

   accelerator_data_feeder dut (
      .clk          (clk),
      .rst          (rst),
      .i_conf_ctrl  (i_conf_ctrl),
      .i_conf_dbase (i_conf_dbase),
      .i_conf_dlen  (i_conf_dlen),
      .i_conf_wbase (i_conf_wbase),
      .i_conf_wlen  (i_conf_wlen),
      .i_data_req   (i_data_req),
      .o_data       (o_data),
      .o_data_val   (o_data_val),
      .o_weight     (o_weight),
      .o_weight_val (o_weight_val),
      .o_dmem_en    (o_dmem_en),
      .o_dmem_addr  (o_dmem_addr),
      .i_dmem_rdata (i_dmem_rdata),
      .o_wmem_en    (o_wmem_en),
      .o_wmem_addr  (o_wmem_addr),
      .i_wmem_rdata (i_wmem_rdata),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address
   function automatic logic [23:0] dword(input logic [9:0] a);
      return {a[7:0] ^ 8'hA5, {a[1:0], a[9:4]}, a[7:0] + 8'd3};
   endfunction

   function automatic logic [95:0] wword(input logic [9:0] a);
      return {dword(a), ~dword(a), dword(a ^ 10'h155), {14'h2A5A, a}};
   endfunction

   // BRAM models, one cycle read latency
   always @(posedge clk) begin
      if (o_dmem_en) i_dmem_rdata <= dword(o_dmem_addr);
      if (o_wmem_en) i_wmem_rdata <= wword(o_wmem_addr);
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      string       name;
      logic [9:0]  wbase;
      logic [10:0] wlen;
      logic [9:0]  dbase;
      logic [10:0] dlen;
      logic [31:0] req_pat;   // bit c = i_data_req during cycle c after the start cycle
      bit          abuse;     // toggle start during the job
      int          exp_done;  // cycle index carrying o_done
   } vec_t;

   function automatic vec_t mk(input string n, input int wb, input int wl, input int db,
                               input int dl, input logic [31:0] pat, input bit ab, input int ed);
      vec_t v;
      v.name = n; v.wbase = 10'(wb); v.wlen = 11'(wl); v.dbase = 10'(db); v.dlen = 11'(dl);
      v.req_pat = pat; v.abuse = ab; v.exp_done = ed;
      return v;
   endfunction

   // Runs one job; caller is positioned 1 time unit after a rising edge
   task automatic run_job(input vec_t v);
      int nw, nd, nwv, ndv, done_cnt, done_cyc;
      int addr_err, val_err, lat_err, busy_err;
      logic prev_wen, prev_den;
      logic [9:0] ea;
      nw = 0; nd = 0; nwv = 0; ndv = 0; done_cnt = 0; done_cyc = -1;
      addr_err = 0; val_err = 0; lat_err = 0; busy_err = 0;
      prev_wen = 1'b0; prev_den = 1'b0;
      i_conf_wbase = v.wbase; i_conf_wlen = v.wlen;
      i_conf_dbase = v.dbase; i_conf_dlen = v.dlen;
      i_conf_ctrl  = 32'h1;
      i_data_req   = v.req_pat[0];
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (v.abuse && c >= 2 && c <= v.exp_done) i_conf_ctrl = ((c % 2) == (v.exp_done % 2)) ? 32'h1 : 32'h0;
         else i_conf_ctrl = 32'h0;
         if (c == 1) begin
            // Config changes mid-job must not matter
            i_conf_wbase = ~v.wbase; i_conf_wlen = 11'd7;
            i_conf_dbase = ~v.dbase; i_conf_dlen = 11'd9;
         end
         i_data_req = (c < 32) ? v.req_pat[c] : 1'b0;
         @(negedge clk);
         if (o_wmem_en) begin
            ea = v.wbase + 10'(nw);
            if (o_wmem_addr != ea) addr_err++;
            nw++;
         end
         if (o_dmem_en) begin
            ea = v.dbase + 10'(nd);
            if (o_dmem_addr != ea) addr_err++;
            nd++;
         end
         if (o_weight_val) begin
            ea = v.wbase + 10'(nwv);
            if (o_weight != wword(ea)) val_err++;
            nwv++;
         end
         if (o_data_val) begin
            ea = v.dbase + 10'(ndv);
            if (o_data != dword(ea)) val_err++;
            ndv++;
         end
         if (o_weight_val != prev_wen) lat_err++;
         if (o_data_val != prev_den) lat_err++;
         if (o_busy != (c < v.exp_done)) busy_err++;
         if (o_done) begin done_cnt++; done_cyc = c; end
         prev_wen = o_wmem_en;
         prev_den = o_dmem_en;
      end
      $display("job %s: wreads=%0d dreads=%0d wvals=%0d dvals=%0d done@%0d",
               v.name, nw, nd, nwv, ndv, done_cyc);
      check({v.name, "/done_count"}, 96'(done_cnt), 96'(1));
      check({v.name, "/done_cycle"}, 96'(done_cyc), 96'(v.exp_done));
      check({v.name, "/wmem_reads"}, 96'(nw), 96'(v.wlen));
      check({v.name, "/dmem_reads"}, 96'(nd), 96'(v.dlen));
      check({v.name, "/weight_vals"}, 96'(nwv), 96'(v.wlen));
      check({v.name, "/data_vals"}, 96'(ndv), 96'(v.dlen));
      check({v.name, "/addr_errors"}, 96'(addr_err), 96'(0));
      check({v.name, "/value_errors"}, 96'(val_err), 96'(0));
      check({v.name, "/latency_errors"}, 96'(lat_err), 96'(0));
      check({v.name, "/busy_errors"}, 96'(busy_err), 96'(0));
      if (v.dlen != 0) begin
         ea = v.dbase + 10'(v.dlen - 1);
         check({v.name, "/data_hold"}, 96'(o_data), 96'(dword(ea)));
      end
      if (v.wlen != 0) begin
         ea = v.wbase + 10'(v.wlen - 1);
         check({v.name, "/weight_hold"}, o_weight, wword(ea));
      end
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/o_data"}, 96'(o_data), 96'(0));
      check({tag, "/o_data_val"}, 96'(o_data_val), 96'(0));
      check({tag, "/o_weight"}, o_weight, 96'(0));
      check({tag, "/o_weight_val"}, 96'(o_weight_val), 96'(0));
      check({tag, "/o_dmem_en"}, 96'(o_dmem_en), 96'(0));
      check({tag, "/o_dmem_addr"}, 96'(o_dmem_addr), 96'(0));
      check({tag, "/o_wmem_en"}, 96'(o_wmem_en), 96'(0));
      check({tag, "/o_wmem_addr"}, 96'(o_wmem_addr), 96'(0));
      check({tag, "/o_busy"}, 96'(o_busy), 96'(0));
      check({tag, "/o_done"}, 96'(o_done), 96'(0));
   endtask

   vec_t vecs[8];

   initial begin
      int dcnt_after, en_after;
      n_chk = 0; n_pass = 0;
      vecs[0] = mk("w2d3",   0,    2, 5,    3, 32'hFFFF_FFFF, 1'b0, 8);
      vecs[1] = mk("gapped", 10,   1, 20,   3, 32'h0000_006E, 1'b0, 8);
      vecs[2] = mk("wrap",   1023, 2, 1022, 4, 32'hFFFF_FFFF, 1'b0, 9);
      vecs[3] = mk("zero",   0,    0, 0,    0, 32'hFFFF_FFFF, 1'b0, 2);
      vecs[4] = mk("w0d2",   7,    0, 100,  2, 32'hFFFF_FFFF, 1'b0, 5);
      vecs[5] = mk("w3d0",   50,   3, 9,    0, 32'hFFFF_FFFF, 1'b0, 5);
      vecs[6] = mk("abuse",  3,    1, 200,  5, 32'hFFFF_FFFF, 1'b1, 9);
      vecs[7] = mk("late",   900,  2, 300,  2, 32'h0000_140E, 1'b0, 14);

      rst = 1'b0; i_conf_ctrl = '0; i_data_req = 1'b0;
      i_conf_dbase = '0; i_conf_dlen = '0; i_conf_wbase = '0; i_conf_wlen = '0;
      i_dmem_rdata = '0; i_wmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_job(vecs[i]);

      // Reset in the middle of a data stream
      i_conf_wbase = 10'd40; i_conf_wlen = 11'd2; i_conf_dbase = 10'd60; i_conf_dlen = 11'd10;
      i_conf_ctrl = 32'h1; i_data_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         i_conf_ctrl = 32'h0;
      end
      @(negedge clk);
      check("midreset/streaming_before", 96'(o_dmem_en), 96'(1));
      #2 rst = 1'b0;
      #1;
      check_all_zero("midreset");
      @(posedge clk); #1;
      rst = 1'b1;
      dcnt_after = 0; en_after = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_done) dcnt_after++;
         if (o_dmem_en || o_wmem_en || o_busy) en_after++;
      end
      $display("post-reset idle window: done pulses=%0d activity=%0d", dcnt_after, en_after);
      check("midreset/no_done", 96'(dcnt_after), 96'(0));
      check("midreset/idle", 96'(en_after), 96'(0));
      @(posedge clk); #1;
      run_job(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
